// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (open-drain clock/data drive).
// Latency: INHIBIT_CYCLES of clock inhibit, then 11 device clocks plus line release before done.
// Backpressure: start is honoured only while idle; requests while busy are dropped.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   data, start          command byte, one-cycle request pulse (data sampled with start)
//   busy, done, ack_err  transfer in progress, end-of-transfer pulse, error flag valid with done
//   ps2c_in, ps2d_in     raw PS/2 line levels (asynchronous to clk)
//   ps2c_oe, ps2d_oe     1 = pull the line low, 0 = release
//
// Optional feature: define PS2_HOST_TX_TIMEOUT_EN to abort a transfer when the device stops
// clocking for TIMEOUT_CYCLES clocks.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE} state_t;

    state_t        state, state_nx;
    logic          c_s1, c_s2, c_prev;
    logic          d_s1, d_s2;
    logic          fall;
    logic [9:0]    frame;     // {stop, parity, data}; bit 0 is the bit on the wire
    logic [3:0]    bit_cnt;   // device falling edges seen so far, stops at 10
    logic [IW-1:0] inh_cnt;
    logic          inh_last;
    logic          err;
    logic          tmo_hit;

    assign fall     = c_prev & ~c_s2;
    assign inh_last = (inh_cnt == IW'(INHIBIT_CYCLES - 1));

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_active;

    assign tmo_active = (state == REQ) || (state == SEND) || (state == ACK);
    assign tmo_hit    = tmo_active && (tmo_cnt == TW'(TIMEOUT_CYCLES));

    // Counts clocks since the last device edge; held at zero outside the clocked phases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (tmo_active && !fall && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_s1    <= 1'b1;
            c_s2    <= 1'b1;
            c_prev  <= 1'b1;
            d_s1    <= 1'b1;
            d_s2    <= 1'b1;
            frame   <= '0;
            bit_cnt <= '0;
            inh_cnt <= '0;
            err     <= 1'b0;
        end else begin
            c_s1   <= ps2c_in;
            c_s2   <= c_s1;
            c_prev <= c_s2;
            d_s1   <= ps2d_in;
            d_s2   <= d_s1;
            case (state)
                IDLE: begin
                    if (start) begin
                        frame   <= {1'b1, ~^data, data};
                        bit_cnt <= '0;
                        inh_cnt <= '0;
                        err     <= 1'b0;
                    end
                end
                INHIBIT: begin
                    if (!inh_last) inh_cnt <= inh_cnt + 1'b1;
                end
                REQ: begin
                    // First edge: bit 0 is already at frame[0], so no shift here.
                    if (fall) bit_cnt <= 4'd1;
                end
                SEND: begin
                    if (fall) begin
                        frame <= {1'b0, frame[9:1]};
                        if (bit_cnt < 4'd10) bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (fall) err <= d_s2;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        ack_err  = 1'b0;
        ps2c_oe  = 1'b0;
        ps2d_oe  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = INHIBIT;
            end
            INHIBIT: begin
                ps2c_oe = 1'b1;
                ps2d_oe = inh_last;     // start bit goes down on the final inhibit clock
                if (inh_last) state_nx = REQ;
            end
            REQ: begin
                ps2d_oe = 1'b1;
                if (fall) state_nx = SEND;
            end
            SEND: begin
                ps2d_oe = ~frame[0];
                // Edge 10 puts the stop bit (released line) out, which ACK also drives.
                if (fall && bit_cnt == 4'd9) state_nx = ACK;
            end
            ACK: begin
                if (fall) state_nx = RELEASE;
            end
            RELEASE: begin
                if (c_s2 && d_s2) begin
                    done     = 1'b1;
                    ack_err  = err;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (tmo_hit) begin
            ps2c_oe  = 1'b0;
            ps2d_oe  = 1'b0;
            done     = 1'b1;
            ack_err  = 1'b1;
            state_nx = IDLE;
        end
        busy = (state != IDLE) && !done;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clocks the host holds ps2c low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max clocks between device clock falling edges (20 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1, single system clock (50 MHz); the block uses only this clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port data, input, 8, command byte; sampled on the cycle start is accepted.
REQ-006 SHALL have port start, input, 1, one-cycle request pulse.
REQ-007 SHALL have port busy, output, 1, high from the cycle after start is accepted until the cycle done pulses.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when a transfer ends.
REQ-009 SHALL have port ack_err, output, 1, valid only while done=1; 1 = device did not ACK or the transfer timed out.
REQ-010 SHALL have ports ps2c_in and ps2d_in, input, 1 each, raw PS/2 clock and data line levels (asynchronous).
REQ-011 SHALL have ports ps2c_oe and ps2d_oe, output, 1 each, 1 = pull the line low (open-drain), 0 = release.

Function
REQ-012 SHALL pass ps2c_in and ps2d_in through 2-flop synchronizers; device clock falling edge = synced ps2c 1->0, detected with one more register stage.
REQ-013 SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, RELEASE.
REQ-014 IDLE: oe outputs 0, busy 0; start=1 latches data, computes odd parity (~^data), clears bit counter, enters INHIBIT.
REQ-015 SHALL ignore start while busy=1; the latched byte is not changed.
REQ-016 INHIBIT: ps2c_oe=1 for INHIBIT_CYCLES clocks; ps2d_oe=1 on the last of these clocks (start bit); then enter REQ.
REQ-017 REQ: ps2c_oe=0, ps2d_oe stays 1; the first falling edge enters SEND and drives bit0.
REQ-018 SEND: on each falling edge drive the next bit: edges 1-8 data[0..7] LSB first, edge 9 parity, edge 10 stop (ps2d_oe=0); ps2d_oe = NOT bit value.
REQ-019 After edge 10, enter ACK; on the next falling edge sample synced ps2d: 0 = ACK ok, 1 = ack_err.
REQ-020 RELEASE: wait until synced ps2c=1 and ps2d=1, then pulse done for one cycle with ack_err and return to IDLE.
REQ-021 Bit counter SHALL be 4 bits and SHALL not wrap; the inhibit counter SHALL saturate at INHIBIT_CYCLES-1.
REQ-022 SHALL never have ps2c_oe=1 outside INHIBIT.

Reset
REQ-023 On reset assert, SHALL immediately (asynchronously) force ps2c_oe=0, ps2d_oe=0, busy=0, done=0, ack_err=0, state=IDLE, and clear all counters and synchronizers to idle-high.
REQ-024 Reset mid-transfer SHALL abort without a done pulse; the first start after reset is accepted normally.

Configuration
REQ-025 With PS2_HOST_TX_TIMEOUT_EN defined: in REQ, SEND and ACK, a counter SHALL reload on each falling edge. Reaching TIMEOUT_CYCLES SHALL release both lines, pulse done with ack_err=1 and go to IDLE; RELEASE is skipped.
REQ-026 Without PS2_HOST_TX_TIMEOUT_EN: no timeout counter SHALL exist; the block waits indefinitely for device edges.

Verification (bench uses INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200)
REQ-027 Send 0xED with the device model clocking and ACKing -> ps2c_oe low 10 clocks; line bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done with ack_err=0.
REQ-028 Send 0x00, then 0xFF -> parity 1, then parity 0; both done with ack_err=0.
REQ-029 Send 0xF4 with the device holding data high on the ACK clock -> done with ack_err=1; busy drops the same cycle.
REQ-030 Pulse start with 0x55 during a 0xED transfer -> the line still carries 0xED; exactly one done pulse.
REQ-031 Assert reset at edge 5 of a transfer -> all oe=0 and busy=0 asynchronously; no done pulse; the next 0xED send completes normally.
REQ-032 With PS2_HOST_TX_TIMEOUT_EN, send with no device clocks -> done and ack_err=1 200 clocks after entering REQ, with both lines released.
